// File: rtl/regsel_serializer.sv
// Serializing one-hot encoder: merges multi-hot write requests into a pending set
// and issues one 5-bit register index per ready/valid handshake.
module regsel_serializer #(
   parameter int unsigned ROUND_ROBIN = 1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [31:0] req_in,
   input  logic        req_load,
   input  logic        flush,
   output logic [4:0]  sel_out,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [5:0]  pending_cnt,
   output logic        busy
);

   logic [31:0] pending;
   logic [4:0]  ptr;
   logic        can_load;
   logic [4:0]  search_start;
   logic [4:0]  search_idx;
   logic        found;
   logic [4:0]  found_idx;
   logic [31:0] clear_mask;
   logic [31:0] pending_next;
   logic [5:0]  cnt_next;

   assign can_load     = !out_valid || out_ready;
   assign search_start = (ROUND_ROBIN != 0) ? ptr : 5'd0;

   // First set bit of the registered pending set, scanning upward from search_start with wrap.
   always_comb begin
      found      = 1'b0;
      found_idx  = '0;
      search_idx = '0;
      for (int unsigned i = 0; i < 32; i++) begin
         search_idx = search_start + 5'(i);
         if (!found && pending[search_idx]) begin
            found     = 1'b1;
            found_idx = search_idx;
         end
      end
   end

   // Clear is applied before the merge so a same-cycle re-request keeps the bit pending.
   always_comb begin
      clear_mask   = (can_load && found) ? (32'd1 << found_idx) : '0;
      pending_next = (pending & ~clear_mask) | (req_load ? req_in : '0);
   end

   always_comb begin
      cnt_next = '0;
      for (int unsigned i = 0; i < 32; i++) begin
         cnt_next = cnt_next + {5'd0, pending_next[i]};
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pending     <= '0;
         pending_cnt <= '0;
         sel_out     <= '0;
         out_valid   <= 1'b0;
         ptr         <= '0;
      end else if (flush) begin
         pending     <= '0;
         pending_cnt <= '0;
         out_valid   <= 1'b0;
         ptr         <= '0;
      end else begin
         pending     <= pending_next;
         pending_cnt <= cnt_next;
         if (can_load) begin
            if (found) begin
               sel_out   <= found_idx;
               out_valid <= 1'b1;
               if (ROUND_ROBIN != 0) begin
                  ptr <= found_idx + 5'd1;
               end
            end else begin
               out_valid <= 1'b0;
            end
         end
      end
   end

   assign busy = (pending != '0) || out_valid;

endmodule

// File: tb/tb_regsel_serializer.sv
// Self-checking bench for regsel_serializer: behavioural model compared every cycle
// plus directed vectors with hand-computed expectations.
module tb_regsel_serializer;

   localparam int RR = 1;

   logic        clk;
   logic        rst_n;
   logic [31:0] req_in;
   logic        req_load;
   logic        flush;
   logic [4:0]  sel_out;
   logic        out_valid;
   logic        out_ready;
   logic [5:0]  pending_cnt;
   logic        busy;

   int checks = 0;
   int errors = 0;

   regsel_serializer #(.ROUND_ROBIN(RR)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .req_in      (req_in),
      .req_load    (req_load),
      .flush       (flush),
      .sel_out     (sel_out),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .pending_cnt (pending_cnt),
      .busy        (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Behavioural model: pending set as a bit array, issue order from plain modulo search.
   bit [31:0] m_pending;
   int        m_ptr;
   bit [4:0]  m_sel;
   bit        m_valid;

   always @(posedge clk or negedge rst_n) begin : model
      bit [31:0] p;
      int        j;
      int        idx;
      if (!rst_n) begin
         m_pending <= '0;
         m_ptr     <= 0;
         m_sel     <= '0;
         m_valid   <= 1'b0;
      end else if (flush) begin
         m_pending <= '0;
         m_ptr     <= 0;
         m_valid   <= 1'b0;
      end else begin
         p = m_pending;
         j = -1;
         if (!m_valid || out_ready) begin
            for (int k = 0; k < 32; k++) begin
               idx = ((RR != 0 ? m_ptr : 0) + k) % 32;
               if (j < 0 && p[idx]) j = idx;
            end
            if (j >= 0) begin
               m_sel   <= j[4:0];
               m_valid <= 1'b1;
               p[j]    = 1'b0;
               if (RR != 0) m_ptr <= (j + 1) % 32;
            end else begin
               m_valid <= 1'b0;
            end
         end
         if (req_load) p = p | req_in;
         m_pending <= p;
      end
   end

   always @(negedge clk) begin
      check("model_valid", {31'd0, out_valid}, {31'd0, m_valid});
      if (m_valid) check("model_sel", {27'd0, sel_out}, {27'd0, m_sel});
      check("model_cnt", {26'd0, pending_cnt}, $countones(m_pending));
      check("model_busy", {31'd0, busy}, {31'd0, (m_pending != 0) || m_valid});
   end

   task automatic step();
      @(negedge clk);
   endtask

   initial begin
      rst_n = 1'b0; req_in = '0; req_load = 1'b0; flush = 1'b0; out_ready = 1'b0;
      step(); step();
      check("rst_valid", {31'd0, out_valid}, 32'd0);
      check("rst_sel", {27'd0, sel_out}, 32'd0);
      check("rst_cnt", {26'd0, pending_cnt}, 32'd0);
      check("rst_busy", {31'd0, busy}, 32'd0);
      rst_n = 1'b1;
      step();

      // single request, two edges to issue
      req_in = 32'h0000_0400; req_load = 1'b1; out_ready = 1'b1;
      step();
      req_in = '0; req_load = 1'b0;
      check("single_cnt1", {26'd0, pending_cnt}, 32'd1);
      check("single_early", {31'd0, out_valid}, 32'd0);
      step();
      check("single_valid", {31'd0, out_valid}, 32'd1);
      check("single_sel", {27'd0, sel_out}, 32'd10);
      check("single_cnt0", {26'd0, pending_cnt}, 32'd0);
      step();
      check("single_once", {31'd0, out_valid}, 32'd0);

      // flush to bring ptr back to 0, then multi-hot round robin
      flush = 1'b1;
      step();
      flush = 1'b0; req_in = 32'h8000_0011; req_load = 1'b1;
      step();
      req_in = '0; req_load = 1'b0;
      check("mh_cnt3", {26'd0, pending_cnt}, 32'd3);
      step();
      check("mh_sel0", {27'd0, sel_out}, 32'd0);
      step();
      check("mh_sel4", {27'd0, sel_out}, 32'd4);
      step();
      check("mh_sel31", {27'd0, sel_out}, 32'd31);
      check("mh_valid31", {31'd0, out_valid}, 32'd1);
      req_in = 32'h0000_0003; req_load = 1'b1;
      step();
      req_in = '0; req_load = 1'b0;
      check("wrap_gap", {31'd0, out_valid}, 32'd0);
      step();
      check("wrap_sel0", {27'd0, sel_out}, 32'd0);
      step();
      check("wrap_sel1", {27'd0, sel_out}, 32'd1);
      step();
      check("wrap_idle", {31'd0, out_valid}, 32'd0);

      // backpressure on {3,5}
      req_in = 32'h0000_0028; req_load = 1'b1; out_ready = 1'b0;
      step();
      req_in = '0; req_load = 1'b0;
      check("bp_cnt2", {26'd0, pending_cnt}, 32'd2);
      for (int c = 0; c < 4; c++) begin
         step();
         check("bp_hold_sel", {27'd0, sel_out}, 32'd3);
         check("bp_hold_valid", {31'd0, out_valid}, 32'd1);
         check("bp_hold_cnt", {26'd0, pending_cnt}, 32'd1);
      end
      out_ready = 1'b1;
      step();
      check("bp_sel5", {27'd0, sel_out}, 32'd5);
      check("bp_cnt0", {26'd0, pending_cnt}, 32'd0);
      step();
      check("bp_done", {31'd0, out_valid}, 32'd0);

      // set-wins collision on bit 7
      req_in = 32'h0000_0080; req_load = 1'b1;
      step();
      check("sw_cnt1", {26'd0, pending_cnt}, 32'd1);
      step();
      req_in = '0; req_load = 1'b0;
      check("sw_first", {27'd0, sel_out}, 32'd7);
      check("sw_keep", {26'd0, pending_cnt}, 32'd1);
      step();
      check("sw_second", {27'd0, sel_out}, 32'd7);
      check("sw_second_v", {31'd0, out_valid}, 32'd1);
      check("sw_cnt0", {26'd0, pending_cnt}, 32'd0);
      step();
      check("sw_idle", {31'd0, out_valid}, 32'd0);

      // flush overrides load and ready
      req_in = 32'hFFFF_FFFF; req_load = 1'b1;
      step();
      req_load = 1'b0; out_ready = 1'b0;
      check("all_cnt32", {26'd0, pending_cnt}, 32'd32);
      step();
      check("all_sel8", {27'd0, sel_out}, 32'd8);
      check("all_cnt31", {26'd0, pending_cnt}, 32'd31);
      flush = 1'b1; req_load = 1'b1; out_ready = 1'b1;
      step();
      flush = 1'b0; req_load = 1'b0; req_in = '0;
      check("fl_cnt", {26'd0, pending_cnt}, 32'd0);
      check("fl_valid", {31'd0, out_valid}, 32'd0);
      check("fl_busy", {31'd0, busy}, 32'd0);

      // async reset mid-stream
      req_in = 32'h0F0F_0F0F; req_load = 1'b1;
      step();
      req_load = 1'b0;
      step(); step();
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      check("ar_valid", {31'd0, out_valid}, 32'd0);
      check("ar_sel", {27'd0, sel_out}, 32'd0);
      check("ar_cnt", {26'd0, pending_cnt}, 32'd0);
      check("ar_busy", {31'd0, busy}, 32'd0);
      step();
      rst_n = 1'b1;
      step(); step();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/regsel_serializer.md
Name: regsel_serializer

Overview:
- Serializing one-hot encoder: the inverse of the register-file 5-to-32 write decoder.
- Collects a 32-bit multi-hot vector of register write requests into a pending set.
- Emits one 5-bit register index per handshake, with a valid flag that drives the decoder's select and write-enable inputs.
- Sits between the write-back request logic and the register-file write decoder, so several simultaneous write requests are serialized into single-register writes.

Parameters:
- ROUND_ROBIN, 1: 1 = rotating priority starting after the last issued index; 0 = fixed priority, lowest index first.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- req_in  input  32  request vector; bit i = register i wants a write
- req_load  input  1  when 1, req_in is OR-merged into the pending set at this edge
- flush  input  1  synchronous clear of all pending and issued state
- sel_out  output  5  index of the issued register (feeds decoder Select)
- out_valid  output  1  sel_out is valid (feeds decoder Wenable)
- out_ready  input  1  consumer accepts sel_out this cycle
- pending_cnt  output  6  number of set bits in the pending set, 0..32
- busy  output  1  (pending set nonzero) OR out_valid

Behaviour:
- State:
  - pending[31:0]
  - sel_out/out_valid output register
  - ptr[4:0] search start
- Reset (rst_n=0, async): pending=0, sel_out=0, out_valid=0, ptr=0, pending_cnt=0, busy=0.
- Handshake:
  - The output register may load when out_valid=0 or (out_valid & out_ready).
  - Otherwise sel_out and out_valid hold stable.
  - No index is dropped or changed while out_valid=1 and out_ready=0.
- Load:
  - Search the registered pending set (current value, before this edge's merge).
  - ROUND_ROBIN=1: search from ptr upward, wrapping 31->0.
  - ROUND_ROBIN=0: search from bit 0.
  - First set bit j found: sel_out<=j, out_valid<=1, clear bit j from pending; if ROUND_ROBIN=1, ptr<=(j+1) mod 32 (31 wraps to 0).
  - None found: out_valid<=0, sel_out holds its last value.
- Pending update each edge: pending <= (pending & ~clear_mask) | (req_load ? req_in : 0).
  - Set wins: if bit j is cleared by a load and re-requested in the same cycle, it stays pending and is issued again later.
  - Re-requesting a bit already pending merges into it; no duplicate is created.
- Latency:
  - req_load at edge t makes the bit pending after edge t.
  - Earliest out_valid is after edge t+1, i.e. 2 edges from request to issue.
- Throughput: one index per cycle while out_ready=1 and pending is nonempty.
- pending_cnt: registered popcount of pending, updated on the same edge as pending.
- busy: combinational from registered state.
- flush=1 at an edge:
  - pending<=0, out_valid<=0, ptr<=0.
  - Overrides req_load and out_ready in the same cycle; req_in is discarded.
- Mid-operation async reset: all state is cleared immediately; the in-flight index is lost and no write-enable glitch may reach the decoder.
- req_in=0 with req_load=1: no effect.

Test Plan:
- Reset then idle: rst_n low for 2 cycles, no requests -> out_valid=0, sel_out=0, pending_cnt=0, busy=0.
- Single request: req_in=32'h00000400, req_load=1 for 1 cycle, out_ready=1 -> sel_out=10, out_valid=1 exactly 2 edges later, for 1 cycle; pending_cnt goes 1 then 0.
- Multi-hot, ROUND_ROBIN=1: ptr=0, req_in=32'h80000011, out_ready=1 -> sel_out sequence 0, 4, 31 on consecutive cycles. Then load 32'h00000003 -> sequence 0, 1 (ptr wrapped to 0 after 31).
- Backpressure: pending {3, 5}, out_ready=0 for 4 cycles -> sel_out=3 and out_valid=1 held steady. Raise out_ready -> 3 then 5 on consecutive cycles; pending_cnt goes 2, 1, 0.
- Set-wins collision: issuing bit 7 while req_load with req_in=32'h00000080 in the same cycle -> 7 is issued twice; pending_cnt never exceeds 1 for that bit.
- Flush and async reset: pending 32'hFFFFFFFF with flush and req_load same cycle -> pending_cnt=0, out_valid=0 next edge. rst_n low mid-stream -> all outputs 0 immediately, before the next clk edge.
